// File: rtl/mem_responder.sv
// Memory-side responder for the MFA/MOC handshake: one request at a time,
// fixed latency, big-endian byte array with a backdoor preload port.
module mem_responder #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        Size,
    input  logic              SE,
    input  logic [31:0]       Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Err,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [7:0]        LdByte
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        din_q, din_d;
    logic [1:0]         size_q, size_d;
    logic               rw_q, rw_d;
    logic               se_q, se_d;
    logic               moc_q, moc_d;
    logic               err_q, err_d;
    logic [31:0]        dout_q, dout_d;

    logic [7:0]         mem [2**ADDR_W];

    logic [ADDR_W-1:0]  a0, a1, a2, a3;
    logic [7:0]         b0, b1, b2, b3;
    logic               fault;
    logic               access;
    logic               wr_go;
    logic [31:0]        rd_data;

    assign a0 = addr_q[ADDR_W-1:0];
    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        fault = (size_q == 2'b11)
             || (size_q == 2'b01 && addr_q[0])
             || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
             || (|addr_q[31:ADDR_W]);
        case (size_q)
            2'b10:   rd_data = {b0, b1, b2, b3};
            2'b01:   rd_data = {(se_q ? {16{b0[7]}} : 16'h0000), b0, b1};
            default: rd_data = {(se_q ? {24{b0[7]}} : 24'h000000), b0};
        endcase
    end

    assign access = (state_q == BUSY) && (cnt_q == '0);
    assign wr_go  = access && !rw_q && !fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        size_d  = size_q;
        rw_d    = rw_q;
        se_d    = se_q;
        moc_d   = moc_q;
        err_d   = err_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (MFA) begin
                    addr_d  = Address;
                    din_d   = DataIn;
                    size_d  = Size;
                    rw_d    = RW;
                    se_d    = SE;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    moc_d   = 1'b1;
                    err_d   = fault;
                    state_d = DONE;
                    if (fault)
                        dout_d = 32'h0;
                    else if (rw_q)
                        dout_d = rd_data;
                end
            end
            DONE: begin
                if (!MFA) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            din_q   <= 32'h0;
            size_q  <= 2'b00;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            se_q    <= se_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Request write is placed after the backdoor so it wins on a shared byte.
    always_ff @(posedge clk) begin
        if (LdEn)
            mem[LdAddr] <= LdByte;
        if (wr_go) begin
            case (size_q)
                2'b10: begin
                    mem[a0] <= din_q[31:24];
                    mem[a1] <= din_q[23:16];
                    mem[a2] <= din_q[15:8];
                    mem[a3] <= din_q[7:0];
                end
                2'b01: begin
                    mem[a0] <= din_q[15:8];
                    mem[a1] <= din_q[7:0];
                end
                default: mem[a0] <= din_q[7:0];
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters).
module tb_mem_responder;

    localparam int ADDR_W  = 9;
    localparam int LATENCY = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              MFA, RW, SE, LdEn;
    logic [1:0]        Size;
    logic [31:0]       Address, DataIn, DataOut;
    logic              MOC, Err;
    logic [ADDR_W-1:0] LdAddr;
    logic [7:0]        LdByte;

    int n_cmp = 0;
    int n_bad = 0;

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .MFA(MFA), .RW(RW), .Size(Size), .SE(SE),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC),
        .Err(Err), .LdEn(LdEn), .LdAddr(LdAddr), .LdByte(LdByte)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] b);
        @(negedge clk);
        LdEn = 1'b1; LdAddr = a; LdByte = b;
        @(negedge clk);
        LdEn = 1'b0;
    endtask

    task automatic start(input logic rw, input logic [1:0] sz, input logic se,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MFA = 1'b1; RW = rw; Size = sz; SE = se; Address = a; DataIn = d;
    endtask

    // Capture edge is the next posedge; counts edges to MOC, optionally
    // scrambles inputs in BUSY and holds MFA in DONE, then drops MFA.
    task automatic finish(input string tag, input logic [31:0] exp_d, input logic exp_e,
                          input int hold, input bit scramble);
        int lat = 0;
        @(posedge clk);
        if (scramble) begin
            #1;
            Address = 32'h0000_0010; DataIn = 32'h0000_00EE; RW = 1'b0; Size = 2'b00;
        end
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (MOC) break;
        end
        check({tag, ".lat"}, lat, LATENCY);
        check({tag, ".moc"}, {31'b0, MOC}, 32'd1);
        check({tag, ".err"}, {31'b0, Err}, {31'b0, exp_e});
        check({tag, ".data"}, DataOut, exp_d);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_moc"}, {31'b0, MOC}, 32'd1);
            check({tag, ".hold_data"}, DataOut, exp_d);
        end
        @(negedge clk);
        MFA = 1'b0;
        @(posedge clk); #1;
        check({tag, ".moc_low"}, {31'b0, MOC}, 32'd0);
        check({tag, ".err_low"}, {31'b0, Err}, 32'd0);
        check({tag, ".data_kept"}, DataOut, exp_d);
    endtask

    initial begin
        rst_n = 1'b0; MFA = 1'b0; RW = 1'b0; Size = 2'b00; SE = 1'b0;
        Address = 32'h0; DataIn = 32'h0; LdEn = 1'b0; LdAddr = '0; LdByte = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.moc", {31'b0, MOC}, 32'd0);
        check("rst.err", {31'b0, Err}, 32'd0);
        check("rst.data", DataOut, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: word read of preloaded bytes
        load(9'h000, 8'h12); load(9'h001, 8'h34); load(9'h002, 8'h56); load(9'h003, 8'h78);
        start(1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        finish("t1.word_rd", 32'h1234_5678, 1'b0, 0, 1'b0);

        // 2: byte write, then signed and unsigned byte reads
        start(1'b0, 2'b00, 1'b0, 32'h10, 32'hFFFF_FF80);
        finish("t2.byte_wr", 32'h1234_5678, 1'b0, 0, 1'b0);
        start(1'b1, 2'b00, 1'b1, 32'h10, 32'h0);
        finish("t2.byte_rd_se", 32'hFFFF_FF80, 1'b0, 0, 1'b0);
        start(1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
        finish("t2.byte_rd", 32'h0000_0080, 1'b0, 0, 1'b0);

        // 3: halfword write, word and halfword reads
        load(9'h022, 8'h00); load(9'h023, 8'h00);
        start(1'b0, 2'b01, 1'b0, 32'h20, 32'h0000_BEEF);
        finish("t3.half_wr", 32'h0000_0080, 1'b0, 0, 1'b0);
        start(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
        finish("t3.word_rd", 32'hBEEF_0000, 1'b0, 0, 1'b0);
        start(1'b1, 2'b01, 1'b1, 32'h20, 32'h0);
        finish("t3.half_rd_se", 32'hFFFF_BEEF, 1'b0, 0, 1'b0);
        start(1'b1, 2'b01, 1'b0, 32'h20, 32'h0);
        finish("t3.half_rd", 32'h0000_BEEF, 1'b0, 0, 1'b0);

        // 4: faults complete the handshake with Err and zero data
        start(1'b1, 2'b10, 1'b0, 32'h2, 32'h0);
        finish("t4.word_misal", 32'h0, 1'b1, 0, 1'b0);
        start(1'b1, 2'b01, 1'b0, 32'h20, 32'h0);
        finish("t4.half_rd2", 32'h0000_BEEF, 1'b0, 0, 1'b0);
        start(1'b0, 2'b01, 1'b0, 32'h21, 32'h0000_1111);
        finish("t4.half_misal", 32'h0, 1'b1, 0, 1'b0);
        start(1'b0, 2'b11, 1'b0, 32'h20, 32'h5555_5555);
        finish("t4.size11", 32'h0, 1'b1, 0, 1'b0);
        start(1'b0, 2'b00, 1'b0, 32'h220, 32'h0000_0077);
        finish("t4.out_of_range", 32'h0, 1'b1, 0, 1'b0);
        start(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
        finish("t4.unchanged", 32'hBEEF_0000, 1'b0, 0, 1'b0);

        // 5: reset during BUSY aborts the write; MFA held across release
        load(9'h030, 8'hAA); load(9'h031, 8'hBB); load(9'h032, 8'hCC); load(9'h033, 8'hDD);
        start(1'b0, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5.rst_moc", {31'b0, MOC}, 32'd0);
        check("t5.rst_data", DataOut, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("t5.rst_hold_moc", {31'b0, MOC}, 32'd0);
        @(negedge clk);
        RW = 1'b1; Size = 2'b10; Address = 32'h30;
        @(negedge clk);
        rst_n = 1'b1;
        finish("t5.after_rst", 32'hAABB_CCDD, 1'b0, 0, 1'b0);

        // 6: hold in DONE, inputs scrambled during BUSY
        start(1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        finish("t6.hold_scramble", 32'h1234_5678, 1'b0, 5, 1'b1);
        start(1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
        finish("t6.no_stray_wr", 32'h0000_0080, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
